tlp_req_be_splitter: RTL and testbench
======================================

TLP_REQ_BE_SPLITTER -- requirements
Module: tlp_req_be_splitter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have parameter MAX_PAYLOAD_BYTES, default 256, per-TLP byte limit; power of 2 in 128..4096.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_addr  input  ADDR_W  start byte address.
REQ-008 SHALL have port cmd_byte_count  input  13  transfer size in bytes, legal 1..4096.
REQ-009 SHALL have port cmd_is_write  input  1  1 = memory write, 0 = memory read.
REQ-010 SHALL have port tlp_valid  output  1  TLP request descriptor present.
REQ-011 SHALL have port tlp_ready  input  1  downstream accepts descriptor.
REQ-012 SHALL have port tlp_addr  output  ADDR_W  DW-aligned address; bits [1:0] always 0.
REQ-013 SHALL have port tlp_length  output  10  length in DW; 1024 DW encoded as 10'h000.
REQ-014 SHALL have port tlp_first_be / tlp_last_be  output  4 each  first/last DW byte enables.
REQ-015 SHALL have port tlp_is_write  output  1  copy of cmd_is_write.
REQ-016 SHALL have port tlp_last  output  1  descriptor is final TLP of the command.
REQ-017 SHALL have port cmd_err  output  1  one-cycle pulse: command rejected.

Function
REQ-018 SHALL use FSM states IDLE, EMIT; cmd_ready = 1 only in IDLE.
REQ-019 SHALL, on accept, latch cur_addr = cmd_addr, remaining = cmd_byte_count and enter EMIT; first descriptor valid the next cycle (latency 1).
REQ-020 SHALL size each chunk = min(remaining, MAX_PAYLOAD_BYTES - (cur_addr mod MAX_PAYLOAD_BYTES)); a TLP therefore never crosses an MPS-aligned or 4 KB boundary.
REQ-021 SHALL set tlp_length = ceil((cur_addr[1:0] + chunk) / 4), tlp_addr = cur_addr with [1:0] cleared.
REQ-022 SHALL set first_be = 4'hF << cur_addr[1:0]; last_be = 4'hF >> (3 - end[1:0]), end = cur_addr + chunk - 1.
REQ-023 SHALL, when tlp_length = 1, emit first_be = AND of both masks and last_be = 4'h0.
REQ-024 SHALL hold all tlp_* outputs stable while tlp_valid && !tlp_ready.
REQ-025 SHALL, on tlp handshake, advance cur_addr += chunk, remaining -= chunk and present next descriptor the following cycle with no bubble (one TLP per cycle sustained).
REQ-026 SHALL assert tlp_last when chunk == remaining; its handshake returns FSM to IDLE, cmd_ready high next cycle.
REQ-027 SHALL, for cmd_byte_count > 4096 or a read with count 0, accept the command, pulse cmd_err the next cycle, emit no TLP, stay in IDLE.
REQ-028 SHALL compute address arithmetic at ADDR_W bits; wrap at 2^ADDR_W is not checked.

Reset
REQ-029 SHALL, while rst_n low, force state IDLE, tlp_valid 0, cmd_err 0, all tlp_* data outputs 0, cur_addr/remaining 0.
REQ-030 SHALL abandon any in-flight command when reset asserts mid-EMIT; no descriptor resumes after release.
REQ-031 SHALL drive cmd_ready 0 during reset and 1 from the first cycle after rst_n deasserts.

Configuration
REQ-032 SHALL, with TLP_REQ_ZLW_EN defined, turn a write with count 0 into one TLP: tlp_length 1, first_be 4'h0, last_be 4'h0, tlp_last 1.
REQ-033 SHALL, without TLP_REQ_ZLW_EN, treat a write with count 0 as an error per REQ-027.

Structure
REQ-034 SHALL place the state enum, BE mask widths, MPS legality constants and the 1024-DW length encoding constant in shared package tlp_req_pkg.
REQ-035 SHALL implement chunk/length/BE arithmetic in combinational sub-module tlp_chunk_be_calc; FSM and registers in the top.

Verification
REQ-036 SHALL cover: write addr 0x1002, count 4 -> one TLP addr 0x1000, len 2, first_be 1100, last_be 0011, tlp_last 1.
REQ-037 SHALL cover: read addr 0x1001, count 2 -> len 1, first_be 0110, last_be 0000.
REQ-038 SHALL cover: MPS 256, addr 0x0FF0, count 64 -> TLP1 0x0FF0 len 4 F/F; TLP2 0x1000 len 12 F/F tlp_last 1, back-to-back cycles.
REQ-039 SHALL cover: tlp_ready low 5 cycles mid-command -> all tlp_* stable, no chunk dropped or duplicated.
REQ-040 SHALL cover: write count 0 addr 0x2000 -> len 1, BE 0/0 with TLP_REQ_ZLW_EN; cmd_err pulse without it; read count 0 -> cmd_err in both builds.
REQ-041 SHALL cover: rst_n low during 3rd TLP of a 4096-byte command -> tlp_valid 0 immediately, cmd_ready 1 one cycle after release.

Source files
------------

// File: rtl/tlp_req_pkg.sv
`default_nettype none
// ============================================================================
// tlp_req_pkg : shared types and constants for the TLP request splitter
// Rev 1.0
// ============================================================================
package tlp_req_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int c_be_w           = 4;
  localparam int c_len_w          = 10;
  localparam int c_byte_cnt_w     = 13;
  localparam int c_max_xfer_bytes = 4096;
  localparam int c_mps_min        = 128;
  localparam int c_mps_max        = 4096;

  // A 1024-DW payload wraps the 10-bit length field to zero.
  localparam logic [c_len_w-1:0] c_len_1024_enc = 10'h000;

  function automatic bit mps_legal(input int mps);
    return (mps >= c_mps_min) && (mps <= c_mps_max) && ((mps & (mps - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_chunk_be_calc.sv
`default_nettype none
// ============================================================================
// tlp_chunk_be_calc : chunk size, DW length and byte enables for one TLP
// Rev 1.0
// ============================================================================
module tlp_chunk_be_calc
  import tlp_req_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 256
) (
  input  logic [$clog2(MAX_PAYLOAD_BYTES)-1:0] addr_lo,
  input  logic [c_byte_cnt_w-1:0]              remaining,
  output logic [c_byte_cnt_w-1:0]              chunk,
  output logic [c_len_w-1:0]                   length,
  output logic [c_be_w-1:0]                    first_be,
  output logic [c_be_w-1:0]                    last_be
);

  logic [c_byte_cnt_w-1:0] w_room;
  logic [c_byte_cnt_w-1:0] w_span;
  logic [c_len_w:0]        w_len_dw;
  logic [1:0]              w_lo;
  logic [1:0]              w_end_lo;
  logic [c_be_w-1:0]       w_first_mask;
  logic [c_be_w-1:0]       w_last_mask;

  assign w_lo   = addr_lo[1:0];
  assign w_room = c_byte_cnt_w'(MAX_PAYLOAD_BYTES) - c_byte_cnt_w'(addr_lo);
  assign chunk  = (remaining < w_room) ? remaining : w_room;

  assign w_span       = c_byte_cnt_w'(w_lo) + chunk + 13'd3;
  assign w_len_dw     = 11'(w_span >> 2);
  assign w_end_lo     = w_lo + chunk[1:0] - 2'd1;
  assign w_first_mask = 4'hF << w_lo;
  assign w_last_mask  = 4'hF >> (2'd3 - w_end_lo);

  always_comb begin
    length   = w_len_dw[c_len_w-1:0];
    first_be = w_first_mask;
    last_be  = w_last_mask;
    // remaining == 0 only reaches here as a zero-length write.
    if (remaining == '0) begin
      length   = 10'd1;
      first_be = '0;
      last_be  = '0;
    end else if (w_len_dw == 11'd1) begin
      first_be = w_first_mask & w_last_mask;
      last_be  = '0;
    end else if (w_len_dw == 11'd1024) begin
      length   = c_len_1024_enc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlp_req_be_splitter.sv
`default_nettype none
// ============================================================================
// tlp_req_be_splitter : splits byte-range commands into MPS-bounded TLP
// request descriptors. Option macro: TLP_REQ_ZLW_EN (zero-length writes).
// Rev 1.0
// ============================================================================
module tlp_req_be_splitter
  import tlp_req_pkg::*;
#(
  parameter int ADDR_W            = 64,
  parameter int MAX_PAYLOAD_BYTES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [c_byte_cnt_w-1:0] cmd_byte_count,
  input  logic                    cmd_is_write,
  output logic                    tlp_valid,
  input  logic                    tlp_ready,
  output logic [ADDR_W-1:0]       tlp_addr,
  output logic [c_len_w-1:0]      tlp_length,
  output logic [c_be_w-1:0]       tlp_first_be,
  output logic [c_be_w-1:0]       tlp_last_be,
  output logic                    tlp_is_write,
  output logic                    tlp_last,
  output logic                    cmd_err
);

  localparam int c_off_w = $clog2(MAX_PAYLOAD_BYTES);

  generate
    if (!mps_legal(MAX_PAYLOAD_BYTES)) begin : g_mps_illegal
      $error("MAX_PAYLOAD_BYTES must be a power of 2 in 128..4096");
    end
  endgenerate

  state_e                  r_state;
  state_e                  w_state_next;
  logic [ADDR_W-1:0]       r_cur_addr;
  logic [c_byte_cnt_w-1:0] r_remaining;
  logic                    r_is_write;
  logic                    r_cmd_err;
  logic                    r_ready_en;

  logic [c_byte_cnt_w-1:0] w_chunk;
  logic [c_len_w-1:0]      w_length;
  logic [c_be_w-1:0]       w_first_be;
  logic [c_be_w-1:0]       w_last_be;
  logic                    w_cmd_fire;
  logic                    w_cmd_bad;
  logic                    w_zero_bad;
  logic                    w_tlp_fire;
  logic                    w_last_chunk;

`ifdef TLP_REQ_ZLW_EN
  assign w_zero_bad = !cmd_is_write;
`else
  assign w_zero_bad = 1'b1;
`endif

  // Held low through reset so no command lands before the first clean edge.
  assign cmd_ready    = r_ready_en && (r_state == IDLE);
  assign w_cmd_fire   = cmd_valid && cmd_ready;
  assign w_cmd_bad    = (cmd_byte_count > c_byte_cnt_w'(c_max_xfer_bytes)) ||
                        ((cmd_byte_count == '0) && w_zero_bad);
  assign tlp_valid    = (r_state == EMIT);
  assign w_tlp_fire   = tlp_valid && tlp_ready;
  assign w_last_chunk = (w_chunk == r_remaining);

  tlp_chunk_be_calc #(
    .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES)
  ) u_calc (
    .addr_lo   (r_cur_addr[c_off_w-1:0]),
    .remaining (r_remaining),
    .chunk     (w_chunk),
    .length    (w_length),
    .first_be  (w_first_be),
    .last_be   (w_last_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire && !w_cmd_bad)   w_state_next = EMIT;
      EMIT:    if (w_tlp_fire && w_last_chunk) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_is_write  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_cmd_err  <= w_cmd_fire && w_cmd_bad;
      if (w_cmd_fire && !w_cmd_bad) begin
        r_cur_addr  <= cmd_addr;
        r_remaining <= cmd_byte_count;
        r_is_write  <= cmd_is_write;
      end else if (w_tlp_fire) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(w_chunk);
        r_remaining <= r_remaining - w_chunk;
      end
    end
  end

  // Descriptor fields are derived from registers only, so they hold under backpressure.
  assign tlp_addr     = tlp_valid ? {r_cur_addr[ADDR_W-1:2], 2'b00} : '0;
  assign tlp_length   = tlp_valid ? w_length   : '0;
  assign tlp_first_be = tlp_valid ? w_first_be : '0;
  assign tlp_last_be  = tlp_valid ? w_last_be  : '0;
  assign tlp_is_write = tlp_valid && r_is_write;
  assign tlp_last     = tlp_valid && w_last_chunk;
  assign cmd_err      = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_tlp_req_be_splitter.sv
`default_nettype none
// ============================================================================
// tb_tlp_req_be_splitter : directed scoreboard bench for tlp_req_be_splitter
// Rev 1.0
// ============================================================================
module tb_tlp_req_be_splitter;

  localparam int ADDR_W = 64;
  localparam int MPS    = 256;

  typedef struct {
    bit          is_err;
    logic [63:0] addr;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    bit          last;
    bit          wr;
    bit          b2b;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [12:0]       cmd_byte_count;
  logic              cmd_is_write;
  logic              tlp_valid;
  logic              tlp_ready;
  logic [ADDR_W-1:0] tlp_addr;
  logic [9:0]        tlp_length;
  logic [3:0]        tlp_first_be;
  logic [3:0]        tlp_last_be;
  logic              tlp_is_write;
  logic              tlp_last;
  logic              cmd_err;

  always #5 clk = ~clk;

  tlp_req_be_splitter #(
    .ADDR_W            (ADDR_W),
    .MAX_PAYLOAD_BYTES (MPS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_byte_count (cmd_byte_count),
    .cmd_is_write   (cmd_is_write),
    .tlp_valid      (tlp_valid),
    .tlp_ready      (tlp_ready),
    .tlp_addr       (tlp_addr),
    .tlp_length     (tlp_length),
    .tlp_first_be   (tlp_first_be),
    .tlp_last_be    (tlp_last_be),
    .tlp_is_write   (tlp_is_write),
    .tlp_last       (tlp_last),
    .cmd_err        (cmd_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_hs  = -10;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_tlp(input logic [63:0] a, input logic [9:0] len, input logic [3:0] fbe,
                          input logic [3:0] lbe, input bit last, input bit wr, input bit b2b);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.len = len; e.fbe = fbe; e.lbe = lbe;
    e.last = last; e.wr = wr; e.b2b = b2b;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.addr = '0; e.len = '0; e.fbe = '0; e.lbe = '0;
    e.last = 1'b0; e.wr = 1'b0; e.b2b = 1'b0;
    q.push_back(e);
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [63:0] a, input int cnt, input bit wr, input bit expect_tlp);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_before_send", {63'd0, cmd_ready}, 64'd1);
    cmd_valid      = 1'b1;
    cmd_addr       = a;
    cmd_byte_count = 13'(cnt);
    cmd_is_write   = wr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("first_tlp_latency", {63'd0, tlp_valid}, {63'd0, expect_tlp});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("scoreboard_drained", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every descriptor handshake or error pulse.
  initial begin : monitor
    exp_t        e;
    bit          stalled = 1'b0;
    logic [63:0] s_addr;
    logic [9:0]  s_len;
    logic [7:0]  s_be;
    logic [1:0]  s_flags;
    forever begin
      @(negedge clk);
      if (tlp_valid && !tlp_ready) begin
        if (stalled) begin
          check("stall_addr", tlp_addr, s_addr);
          check("stall_len", 64'(tlp_length), 64'(s_len));
          check("stall_be", 64'({tlp_first_be, tlp_last_be}), 64'(s_be));
          check("stall_flags", 64'({tlp_is_write, tlp_last}), 64'(s_flags));
        end
        s_addr  = tlp_addr;
        s_len   = tlp_length;
        s_be    = {tlp_first_be, tlp_last_be};
        s_flags = {tlp_is_write, tlp_last};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end

      if (tlp_valid && tlp_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_tlp: got addr 0x%0h with empty scoreboard", tlp_addr);
        end else begin
          e = q.pop_front();
          check("tlp_not_err", {63'd0, e.is_err}, 64'd0);
          check("tlp_addr", tlp_addr, e.addr);
          check("tlp_length", 64'(tlp_length), 64'(e.len));
          check("tlp_first_be", 64'(tlp_first_be), 64'(e.fbe));
          check("tlp_last_be", 64'(tlp_last_be), 64'(e.lbe));
          check("tlp_last", {63'd0, tlp_last}, {63'd0, e.last});
          check("tlp_is_write", {63'd0, tlp_is_write}, {63'd0, e.wr});
          if (e.b2b) check("back_to_back", 64'(cyc - last_hs), 64'd1);
        end
        last_hs = cyc;
      end

      if (cmd_err) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cmd_err: got pulse with empty scoreboard");
        end else begin
          e = q.pop_front();
          check("cmd_err_expected", {63'd0, e.is_err}, 64'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_addr       = '0;
    cmd_byte_count = '0;
    cmd_is_write   = 1'b0;
    tlp_ready      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("reset_tlp_valid", {63'd0, tlp_valid}, 64'd0);
    check("reset_cmd_err", {63'd0, cmd_err}, 64'd0);
    check("reset_tlp_addr", tlp_addr, 64'd0);
    check("reset_tlp_length", 64'(tlp_length), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);

    // Write 0x1002 / 4 bytes: straddles two DWs.
    push_tlp(64'h1002 & ~64'h3, 10'd2, 4'b1100, 4'b0011, 1'b1, 1'b1, 1'b0);
    send(64'h1002, 4, 1'b1, 1'b1);
    wait_done();

    // Read 0x1001 / 2 bytes: single DW, merged enables.
    push_tlp(64'h1000, 10'd1, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0);
    send(64'h1001, 2, 1'b0, 1'b1);
    wait_done();

    // 0x0FF0 / 64 bytes: split at the 4 KB boundary, back-to-back.
    push_tlp(64'h0FF0, 10'd4, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    push_tlp(64'h1000, 10'd12, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
    send(64'h0FF0, 64, 1'b1, 1'b1);
    wait_done();

    // 0x10FE / 3 bytes: 2 bytes up to the MPS boundary then 1 byte.
    push_tlp(64'h10FC, 10'd1, 4'b1100, 4'b0000, 1'b0, 1'b0, 1'b0);
    push_tlp(64'h1100, 10'd1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
    send(64'h10FE, 3, 1'b0, 1'b1);
    wait_done();

    // 0x3000 / 1024 bytes with a 5-cycle stall after the first TLP.
    for (int i = 0; i < 4; i++)
      push_tlp(64'h3000 + 64'(i * 256), 10'd64, 4'hF, 4'hF, (i == 3), 1'b1, 1'b0);
    send(64'h3000, 1024, 1'b1, 1'b1);
    @(posedge clk); #1;
    tlp_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    tlp_ready = 1'b1;
    wait_done();

    // Zero-length write.
`ifdef TLP_REQ_ZLW_EN
    push_tlp(64'h2000, 10'd1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    send(64'h2000, 0, 1'b1, 1'b1);
`else
    push_err();
    send(64'h2000, 0, 1'b1, 1'b0);
`endif
    wait_done();

    // Zero-length read and oversize count are always rejected.
    push_err();
    send(64'h2000, 0, 1'b0, 1'b0);
    wait_done();
    push_err();
    send(64'h4000, 4097, 1'b1, 1'b0);
    wait_done();

    // 4096-byte command at the max legal count, reset during the 3rd TLP.
    push_tlp(64'h6000, 10'd64, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    push_tlp(64'h6100, 10'd64, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
    send(64'h6000, 4096, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("third_tlp_addr", tlp_addr, 64'h6200);
    rst_n = 1'b0;
    #1;
    check("mid_reset_tlp_valid", {63'd0, tlp_valid}, 64'd0);
    check("mid_reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("mid_reset_tlp_addr", tlp_addr, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_scoreboard", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    check("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("post_reset_no_resume", {63'd0, tlp_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
